// File: rtl/gauss_window_3x3.sv
// gauss_window_3x3: raster-order RGB stream to 3x3 neighbourhood windows via two line buffers.
// Edge taps replicate the nearest in-frame pixel; define ZERO_PAD_EN to drive them to zero instead.
module gauss_window_3x3 #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DATA_W   = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  output logic [9*DATA_W-1:0] out_win,
  output logic [9:0]          out_x,
  output logic [8:0]          out_y,
  output logic                out_sof,
  output logic                out_eof,
  output logic                busy,
  output logic                err_overrun
);
  localparam int unsigned AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  Y_LAST = 9'(V_ACTIVE - 1);
  localparam logic [10:0] F_LAST = 11'(H_ACTIVE + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;
  state_t r_state;

  logic [DATA_W-1:0] r_lb1 [H_ACTIVE];
  logic [DATA_W-1:0] r_lb2 [H_ACTIVE];
  logic [DATA_W-1:0] r_c0 [3];
  logic [DATA_W-1:0] r_c1 [3];
  logic [9:0]        r_ix;
  logic [8:0]        r_iy;
  logic [9:0]        r_ox;
  logic [8:0]        r_oy;
  logic [10:0]       r_fcnt;

  logic                w_take, w_restart, w_adv, w_emit, w_ovr, w_flushing;
  logic [AW-1:0]       w_addr;
  logic [DATA_W-1:0]   w_lb1_q, w_lb2_q;
  logic [DATA_W-1:0]   w_cols [3][3];
  logic                w_rpad [3];
  logic                w_cpad [3];
  logic [9*DATA_W-1:0] w_win;

  assign w_flushing = (r_state == S_FLUSH) && (r_fcnt != F_LAST);
  assign w_restart  = in_valid && in_sof && (r_state != S_FLUSH);
  assign w_take     = in_valid && (((r_state == S_IDLE) && in_sof) ||
                                   (r_state == S_FILL) || (r_state == S_RUN));
  assign w_adv      = w_take || w_flushing;
  assign w_emit     = ((r_state == S_RUN) && in_valid && !in_sof) || w_flushing;
  assign w_ovr      = in_valid && (r_state == S_FLUSH);
  assign w_addr     = w_restart ? '0 : r_ix[AW-1:0];
  assign w_lb1_q    = r_lb1[w_addr];
  assign w_lb2_q    = r_lb2[w_addr];
  assign busy       = (r_state != S_IDLE);

  // Window after this cycle's shift: two held columns plus the column being read in now.
  // The centre always sits H+1 pixels behind the newest column, so clamping is a tap mux.
  always_comb begin
    w_cols[0] = r_c0;
    w_cols[1] = r_c1;
    w_cols[2][0] = w_lb2_q;
    w_cols[2][1] = w_lb1_q;
    w_cols[2][2] = in_data;
    w_rpad[0] = (r_oy == '0);
    w_rpad[1] = 1'b0;
    w_rpad[2] = (r_oy == Y_LAST);
    w_cpad[0] = (r_ox == '0);
    w_cpad[1] = 1'b0;
    w_cpad[2] = (r_ox == X_LAST);
  end

  always_comb begin
    w_win = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
`ifdef ZERO_PAD_EN
        if (!(w_rpad[r] || w_cpad[c]))
          w_win[(r*3+c)*DATA_W +: DATA_W] = w_cols[c][r];
`else
        w_win[(r*3+c)*DATA_W +: DATA_W] =
          w_cols[w_cpad[c] ? 2'd1 : 2'(c)][w_rpad[r] ? 2'd1 : 2'(r)];
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_take) begin
      r_lb1[w_addr] <= in_data;
      r_lb2[w_addr] <= w_lb1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ix        <= '0;
      r_iy        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_fcnt      <= '0;
      r_c0        <= '{default: '0};
      r_c1        <= '{default: '0};
      out_valid   <= 1'b0;
      out_win     <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      out_valid <= w_emit;
      out_sof   <= w_emit && (r_ox == '0) && (r_oy == '0);
      out_eof   <= w_emit && (r_ox == X_LAST) && (r_oy == Y_LAST);
      if (w_emit) begin
        out_win <= w_win;
        out_x   <= r_ox;
        out_y   <= r_oy;
        if (r_ox == X_LAST) begin
          r_ox <= '0;
          r_oy <= r_oy + 1'b1;
        end else begin
          r_ox <= r_ox + 1'b1;
        end
      end
      if (w_adv) begin
        r_c0 <= r_c1;
        r_c1 <= w_cols[2];
        if (!w_restart) begin
          if (r_ix == X_LAST) begin
            r_ix <= '0;
            r_iy <= r_iy + 1'b1;
          end else begin
            r_ix <= r_ix + 1'b1;
          end
        end
      end
      if (w_ovr)
        err_overrun <= 1'b1;

      if (w_restart) begin
        r_state <= S_FILL;
        r_ix    <= 10'd1;
        r_iy    <= '0;
        r_ox    <= '0;
        r_oy    <= '0;
      end else begin
        case (r_state)
          S_FILL:
            if (in_valid && (r_ix == '0) && (r_iy == 9'd1))
              r_state <= S_RUN;
          S_RUN:
            if (in_valid && (r_ix == X_LAST) && (r_iy == Y_LAST)) begin
              r_state <= S_FLUSH;
              r_fcnt  <= '0;
            end
          S_FLUSH:
            if (r_fcnt == F_LAST)
              r_state <= S_IDLE;
            else
              r_fcnt <= r_fcnt + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gauss_window_3x3.sv
// Self-checking bench for gauss_window_3x3 at 4x3: frame-level reference model plus literal anchors.
module tb_gauss_window_3x3;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int DW = 24;

  logic            clock, reset, in_valid, in_sof;
  logic [DW-1:0]   in_data;
  logic            out_valid, out_sof, out_eof, busy, err_overrun;
  logic [9*DW-1:0] out_win;
  logic [9:0]      out_x;
  logic [8:0]      out_y;

  gauss_window_3x3 #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_win(out_win), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .err_overrun(err_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: frame pixels kept by linear index; a centre's window is read with clamped coordinates.
  logic [DW-1:0]   pix [H*V];
  int              cyc = 0;
  int              m_phase = 0, m_k = 0, m_next = 0, m_rem = 0;
  logic            m_err = 1'b0;
  logic            e_valid = 1'b0, e_sof = 1'b0, e_eof = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [9*DW-1:0] e_win = '0;
  int              e_x = 0, e_y = 0;

  function automatic logic [9*DW-1:0] model_win(input int cx, input int cy);
    logic [9*DW-1:0] w;
    int xx, yy;
    bit oob;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        xx = cx + c - 1; yy = cy + r - 1; oob = 0;
        if (xx < 0)     begin xx = 0;     oob = 1; end
        if (xx > H - 1) begin xx = H - 1; oob = 1; end
        if (yy < 0)     begin yy = 0;     oob = 1; end
        if (yy > V - 1) begin yy = V - 1; oob = 1; end
`ifdef ZERO_PAD_EN
        w[(r*3+c)*DW +: DW] = oob ? '0 : pix[yy*H + xx];
`else
        w[(r*3+c)*DW +: DW] = pix[yy*H + xx];
`endif
      end
    return w;
  endfunction

  task automatic emit(input int n);
    e_valid = 1'b1;
    e_x     = n % H;
    e_y     = n / H;
    e_win   = model_win(n % H, n / H);
    e_sof   = (n == 0);
    e_eof   = (n == H*V - 1);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0;
      if (reset) begin
        m_phase = 0;
        m_err   = 1'b0;
      end else begin
        case (m_phase)
          0: if (in_valid && in_sof) begin pix[0] = in_data; m_k = 1; m_phase = 1; end
          1: if (in_valid) begin
               if (in_sof) begin
                 pix[0] = in_data; m_k = 1;
               end else begin
                 pix[m_k] = in_data;
                 if (m_k >= H + 1) emit(m_k - H - 1);
                 m_k++;
                 if (m_k == H*V) begin m_phase = 2; m_next = m_k - H - 1; m_rem = H + 1; end
               end
             end
          default: begin
            if (in_valid) m_err = 1'b1;
            if (m_rem > 0) begin emit(m_next); m_next++; m_rem--; end
            else m_phase = 0;
          end
        endcase
      end
      e_busy = (m_phase != 0);
      e_err  = m_err;
    end
  end

  // Per-cycle comparison plus bookkeeping used by the literal anchors.
  int              n_out = 0, n_sof = 0, n_eof = 0;
  int              first_cyc = -1, last_cyc = -1;
  logic [9*DW-1:0] first_win = '0, last_win = '0;
  logic            busy_at_last = 1'b0, busy_after = 1'b1;

  initial begin
    forever begin
      @(negedge clock);
      check("valid", out_valid, e_valid);
      check("busy", busy, e_busy);
      check("err_overrun", err_overrun, e_err);
      if (e_valid) begin
        check("win", out_win, e_win);
        check("x", out_x, e_x);
        check("y", out_y, e_y);
        check("sof", out_sof, e_sof);
        check("eof", out_eof, e_eof);
      end
      if (out_valid) n_out++;
      if (out_valid && out_sof) begin n_sof++; first_cyc = cyc; first_win = out_win; end
      if (out_valid && out_eof) begin
        n_eof++; last_cyc = cyc; last_win = out_win; busy_at_last = busy;
      end
      if (cyc == last_cyc + 1) busy_after = busy;
    end
  end

  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    @(posedge clock); #1;
    in_valid = v; in_sof = s; in_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  function automatic logic [9*DW-1:0] win9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    logic [9*DW-1:0] w;
    w = {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
    return w;
  endfunction

  logic [9*DW-1:0] exp_first, exp_last;
  int n0, s0, e0, acc5, acc11;

  initial begin
`ifdef ZERO_PAD_EN
    exp_first = win9(0, 0, 0,  0, 0, 1,  0, 4, 5);
    exp_last  = win9(6, 7, 0,  10, 11, 0,  0, 0, 0);
`else
    exp_first = win9(0, 0, 1,  0, 0, 1,  4, 4, 5);
    exp_last  = win9(6, 7, 7,  10, 11, 11,  10, 11, 11);
`endif
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_overrun, 1'b0);
    check("rst_win", out_win, '0);
    check("rst_xy", {out_x, out_y}, '0);

    // Continuous full frame.
    n0 = n_out; e0 = n_eof;
    for (int i = 0; i < H*V; i++) begin
      drive(1'b1, i == 0, DW'(i));
      if (i == 5)  acc5  = cyc + 1;
      if (i == 11) acc11 = cyc + 1;
    end
    idle(10);
    check("f1_count", n_out - n0, 12);
    check("f1_eof_count", n_eof - e0, 1);
    check("f1_first_cyc", first_cyc, acc5);
    check("f1_first_win", first_win, exp_first);
    check("f1_last_cyc", last_cyc, acc11 + 5);
    check("f1_last_win", last_win, exp_last);
    check("f1_busy_at_last", busy_at_last, 1'b1);
    check("f1_busy_after", busy_after, 1'b0);

    // Same frame with random input gaps.
    n0 = n_out; e0 = n_eof;
    for (int i = 0; i < H*V; i++) begin
      drive(1'b1, i == 0, DW'(i));
      idle($urandom_range(1, 3));
    end
    idle(10);
    check("f2_count", n_out - n0, 12);
    check("f2_eof_count", n_eof - e0, 1);
    check("f2_first_win", first_win, exp_first);
    check("f2_last_win", last_win, exp_last);

    // Restart at index 7, then inputs during flush.
    n0 = n_out; s0 = n_sof; e0 = n_eof;
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, DW'(i));
    for (int i = 0; i < H*V; i++) begin
      drive(1'b1, i == 0, DW'(i));
      if (i == 5) acc5 = cyc + 1;
    end
    drive(1'b1, 1'b1, 24'h00abcd);
    drive(1'b1, 1'b0, 24'h001234);
    idle(10);
    check("f3_count", n_out - n0, 14);
    check("f3_sof_count", n_sof - s0, 2);
    check("f3_eof_count", n_eof - e0, 1);
    check("f3_first_cyc", first_cyc, acc5);
    check("f3_last_win", last_win, exp_last);
    check("f3_err_set", err_overrun, 1'b1);

    // A clean frame leaves the sticky error in place.
    n0 = n_out;
    for (int i = 0; i < H*V; i++) drive(1'b1, i == 0, DW'(i));
    idle(10);
    check("f4_count", n_out - n0, 12);
    check("f4_err_sticky", err_overrun, 1'b1);

    // Reset mid-RUN, then a fresh frame.
    for (int i = 0; i < 9; i++) drive(1'b1, i == 0, DW'(i));
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("f5_rst_valid", out_valid, 1'b0);
    check("f5_rst_busy", busy, 1'b0);
    check("f5_rst_err", err_overrun, 1'b0);
    n0 = n_out; e0 = n_eof;
    for (int i = 0; i < H*V; i++) drive(1'b1, i == 0, DW'(i));
    idle(10);
    check("f5_count", n_out - n0, 12);
    check("f5_eof_count", n_eof - e0, 1);
    check("f5_first_win", first_win, exp_first);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
